// File: rtl/noc_pkg.sv
// Shared types and constants for the tree NoC router: packet layout, port indices
// and the output-buffer state encoding.
package noc_pkg;

  localparam int WIDTH_packet = 14;
  typedef logic [WIDTH_packet-1:0] packet_t;

  // Packet layout, MSB to LSB: dest | addr | payload
  localparam int WIDTH_payload = 8;
  localparam int PAYLOAD_LSB   = 0;
  localparam int WIDTH_addr    = 3;
  localparam int ADDR_LSB      = PAYLOAD_LSB + WIDTH_payload;
  localparam int WIDTH_dest    = 3;
  localparam int DEST_LSB      = ADDR_LSB + WIDTH_addr;

  localparam int PORT_LEFT   = 0;
  localparam int PORT_RIGHT  = 1;
  localparam int PORT_PARENT = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr (wrapping) wins.
// gnt is asserted only when enable is high; gnt_idx is valid whenever any is high.
module rr_arbiter #(
  parameter int NUM_IN = 3,
  localparam int IDX_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);
  import noc_pkg::*;

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_IN);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_L) cand = cand - N_L;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (enable && found) gnt[gnt_idx] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/tree_port_arbiter.sv
// Output-port scheduler for one tree NoC router node: round-robin over the input
// controllers into a single registered output buffer, one packet per cycle.
module tree_port_arbiter #(
  parameter int WIDTH_packet = noc_pkg::WIDTH_packet,
  parameter int NUM_IN       = 3,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = $clog2(NUM_IN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           out_valid,
  output logic [WIDTH_packet-1:0]        out_data,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               grant_id,
  output logic [CNT_W-1:0]               pkt_count
);
  import noc_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  buf_state_t              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        win_idx;
  logic [NUM_IN-1:0]       gnt;
  logic                    any_req;
  logic                    can_load;
  logic                    accept;
  logic [WIDTH_packet-1:0] buf_data_p1;
  logic [IDX_W-1:0]        buf_src_p1;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH_packet-1:0] lane [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lane[g] = in_data[g*WIDTH_packet +: WIDTH_packet];
  end

  // Stage p0: combinational arbitration; out_ready may reach in_ready directly
  assign can_load = (state_q == ST_EMPTY) | out_ready;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .enable  (can_load & ~rst),
    .gnt     (gnt),
    .gnt_idx (win_idx),
    .any     (any_req)
  );

  assign in_ready = gnt;
  assign accept   = |gnt;

  always_comb begin
    state_d = state_q;
    if (accept)                              state_d = ST_FULL;
    else if (state_q == ST_FULL && out_ready) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Stage p1: one-entry output buffer, replaced on accept even while draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_p1 <= '0;
      buf_src_p1  <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      buf_data_p1 <= lane[win_idx];
      buf_src_p1  <= win_idx;
      rr_ptr      <= (win_idx == IDX_W'(NUM_IN-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= sat_inc(cnt_q);
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = buf_data_p1;
  assign grant_id  = buf_src_p1;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_tree_port_arbiter.sv
// Bench for tree_port_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the output port.
module tb_tree_port_arbiter;
  localparam int W  = 14;
  localparam int N  = 3;
  localparam int CW = 4;
  localparam int IW = $clog2(N);
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;
  logic [IW-1:0]  grant_id;
  logic [CW-1:0]  pkt_count;

  tree_port_arbiter #(.WIDTH_packet(W), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: which source the port will serve next, what sits in the buffer, how many left
  int           m_ptr;
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_cnt;

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_src = 0; m_cnt = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic cycle(output int taken);
    int w;
    logic [N-1:0] exp_rdy;
    w = m_winner();
    exp_rdy = '0;
    if ((!m_full || out_ready) && w >= 0) exp_rdy[w] = 1'b1;
    taken = (exp_rdy != '0) ? w : -1;
    #1 chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_full && out_ready && m_cnt < CMAX) m_cnt++;
    if (taken >= 0) begin
      m_data = in_data[taken*W +: W];
      m_src  = taken;
      m_full = 1;
      m_ptr  = (taken + 1) % N;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_src));
    chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    int t;
    for (int i = 0; i < n; i++) cycle(t);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  bit           pend  [N];
  logic [W-1:0] pdata [N];

  initial begin
    int t;
    model_reset();
    in_valid = 3'b111;
    @(negedge clk);
    do_reset();

    // Load 1A5 from input 1 so the pointer moves off 0, then reset with the buffer full
    in_valid = 3'b010; set_lane(1, 14'h1A5); out_ready = 1'b0;
    cycle(t);
    chk("full_1a5", 32'(out_data), 32'h1A5);
    in_valid = 3'b111;
    set_lane(0, 14'h0AA); set_lane(1, 14'h1BB); set_lane(2, 14'h2CC);
    do_reset();
    out_ready = 1'b1;
    cycle(t);
    chk("first_grant_after_rst", 32'(grant_id), 32'd0);

    // Single requester streaming
    do_reset();
    in_valid = 3'b010; set_lane(1, 14'h0F3); out_ready = 1'b1;
    cycles(4);
    in_valid = 3'b000;
    cycle(t);
    chk("single_count4", 32'(pkt_count), 32'd4);

    // Full contention: grants rotate 0,1,2,...
    do_reset();
    in_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      cycle(t);
      chk("rotate", 32'(grant_id), 32'(i % 3));
    end

    // Backpressure with input 2's packet held, then drain+accept on one edge
    in_valid = 3'b100; set_lane(2, 14'h2C1);
    cycle(t);
    in_valid = 3'b001; set_lane(0, 14'h055); out_ready = 1'b0;
    cycles(5);
    chk("bp_hold", 32'(out_data), 32'h2C1);
    out_ready = 1'b1;
    cycle(t);
    chk("bp_replace", 32'(out_data), 32'h055);

    // Wrap: pointer at 2, inputs 0 and 1 requesting
    in_valid = 3'b010;
    cycle(t);
    in_valid = 3'b011;
    cycle(t);
    chk("wrap_first", 32'(grant_id), 32'd0);
    cycle(t);
    chk("wrap_second", 32'(grant_id), 32'd1);
    in_valid = 3'b000;
    cycles(2);

    // Counter saturation
    do_reset();
    in_valid = 3'b001; set_lane(0, 14'h3FF);
    cycles(20);
    in_valid = 3'b000;
    cycle(t);
    chk("sat_count", 32'(pkt_count), 32'(CMAX));

    // Randomized traffic honouring the hold-until-accepted contract
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdata[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]  = 1;
          pdata[i] = W'($urandom());
        end
        in_valid[i] = pend[i];
        set_lane(i, pdata[i]);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      cycle(t);
      if (t >= 0) pend[t] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tree_port_arbiter.md
Name: tree_port_arbiter

Overview:
- Clocked output-port scheduler for one router node of the tree NoC.
- Shares a single downstream output link among NUM_IN input controllers (left child, right child, parent). Each input controller has already routed a packet to this port.
- Uses round-robin arbitration, a one-entry registered output buffer, and valid/ready handshakes on every side.
- Sustains one packet per cycle. Starvation-free: a waiting requester is served within NUM_IN-1 grants.

Parameters:
- WIDTH_packet, 14, packet width in bits (dest + addr + payload fields), carried opaquely.
- NUM_IN, 3, number of requesting input controllers, minimum 2.
- CNT_W, 16, width of the forwarded-packet counter.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  NUM_IN  per-requester packet valid.
- in_data  in  NUM_IN*WIDTH_packet  requester i occupies bits [i*WIDTH_packet +: WIDTH_packet].
- in_ready  out  NUM_IN  one-hot-or-zero accept, combinational.
- out_valid  out  1  output buffer holds a packet.
- out_data  out  WIDTH_packet  buffered packet, registered.
- out_ready  in  1  downstream accepts.
- grant_id  out  $clog2(NUM_IN)  source index of the packet in the output buffer.
- pkt_count  out  CNT_W  packets delivered downstream, saturating.

Behaviour:
- Reset (async assert, sync release) values:
  - out_valid=0, out_data=0, grant_id=0, pkt_count=0.
  - rr_ptr=0; FSM goes to EMPTY.
  - A buffered packet present at reset is discarded.
  - in_ready=0 while rst is high.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | out_ready.
- Arbitration (combinational):
  - Search in_valid starting at index rr_ptr, ascending, wrapping NUM_IN-1 -> 0. The first set bit wins.
  - in_ready[win] = can_load & any(in_valid). All other in_ready bits are 0.
- Accept (in_valid[i] & in_ready[i] at a clock edge):
  - out_data <= in_data[i]; grant_id <= i; next state FULL.
  - rr_ptr <= (i==NUM_IN-1) ? 0 : i+1.
- Drain (FULL & out_ready at a clock edge) with no accept in the same cycle: next state EMPTY. out_data and grant_id hold their old values.
- Simultaneous drain and accept: the buffer is replaced in the same edge and stays FULL. Throughput is 1 packet/cycle, with no bubble.
- FULL & !out_ready: out_data and grant_id are stable, in_ready is all 0, and rr_ptr is frozen.
- Latency: a packet accepted at edge N is presented on out_data from after edge N (one cycle, registered).
- pkt_count increments on each out_valid & out_ready. It saturates at 2^CNT_W-1 and does not wrap.
- Requester contract: in_valid and in_data stay stable until accepted. The arbiter never latches from an input whose in_ready is low.
- No combinational path from in_valid to out_valid. A combinational path from out_ready to in_ready is permitted (single-entry buffer).
- Single requester continuously valid: it is granted every cycle while can_load holds.
- All inputs valid: grants rotate 0,1,2,0,...

Decomposition:
- Package noc_pkg holds:
  - WIDTH_packet and the packet_t typedef.
  - Field localparams: DEST_LSB/WIDTH_dest=3, ADDR_LSB/WIDTH_addr=3, PAYLOAD width 8.
  - Port-index constants PORT_LEFT=0, PORT_RIGHT=1, PORT_PARENT=2.
- Sub-module rr_arbiter is purely combinational:
  - Inputs: req[NUM_IN], ptr, enable.
  - Outputs: gnt one-hot, gnt_idx, any.
  - It is reused by the later per-port schedulers.
- tree_port_arbiter itself contains the FSM, the buffer, rr_ptr and the counter.

Test Plan:
- Reset mid-operation: buffer FULL with 14'h1A5 and out_ready=0, then pulse rst between clock edges -> out_valid drops immediately, pkt_count=0, and the first grant after release goes to input 0.
- Single requester: in_valid=3'b010 with in_data[1]=14'h0F3 and out_ready=1 -> in_ready=3'b010 every cycle; out_data=14'h0F3, grant_id=1 one cycle later; 4 packets in 4 cycles give pkt_count=4.
- Full contention: in_valid=3'b111 held, out_ready=1 -> grant_id sequence 0,1,2,0,1,2; 6 packets in 6 consecutive cycles.
- Backpressure: buffer FULL (grant_id=2, out_data=14'h2C1), out_ready=0 for 5 cycles -> in_ready=0, out_data stable. Then out_ready=1 with in_valid=3'b001 -> drain and accept on the same edge; next out_data is input 0's packet.
- Wrap and fairness: rr_ptr=2, in_valid=3'b011 -> input 0 wins, then input 1. Input 1 waits at most 2 grants.
- Counter saturation: with CNT_W=4, forward 20 packets -> pkt_count stops at 15.
